// File: rtl/mem_bus_pkg.sv
// Shared definitions for the board memory-port arbiter: FSM states,
// the error read-data pattern and the IO window base address.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
    localparam logic [31:0] IO_BASE   = 32'h0010_0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on the last committed winner, or fixed
// priority to requester 1 when fixed_prio is set.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       fixed_prio,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       id
);

    logic last;

    always_comb begin
        valid = |req;
        id    = 1'b0;
        if (req == 2'b11) begin
            id = fixed_prio ? 1'b1 : ~last;
        end else if (req[1]) begin
            id = 1'b1;
        end
    end

    // Reset value 1 makes requester 0 the winner of the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (take && valid) begin
            last <= id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single controller memory port between an instruction port (p0)
// and a data port (p1); serialises transactions and aborts hung ones.
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        grant,
    output logic        busy
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t state;
    logic       op_read;
    logic       op_write;
    logic [7:0] count;
    logic [1:0] req;
    logic       win_valid;
    logic       win_id;

    // A port whose ack is high this cycle is dropping that request; do not re-grant it.
    assign req[0] = (p0_read | p0_write) & ~p0_ack;
    assign req[1] = (p1_read | p1_write) & ~p1_ack;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .fixed_prio (FIXED_PRIO),
        .req        (req),
        .take       (state == IDLE),
        .valid      (win_valid),
        .id         (win_id)
    );

    // Dropping the request in the ack cycle stops the controller restarting it.
    assign m_read  = op_read & ~m_ack;
    assign m_write = op_write & ~m_ack;
    assign busy    = (state == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_read  <= 1'b0;
            op_write <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            grant    <= 1'b0;
            count    <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p1_err   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant <= win_id;
                        count <= '0;
                        state <= BUSY;
                        if (win_id) begin
                            m_addr   <= p1_addr;
                            m_wdata  <= p1_wdata;
                            op_write <= p1_write;
                            op_read  <= p1_read & ~p1_write;
                        end else begin
                            m_addr   <= p0_addr;
                            m_wdata  <= p0_wdata;
                            op_write <= p0_write;
                            op_read  <= p0_read & ~p0_write;
                        end
                    end
                end
                BUSY: begin
                    count <= count + 8'd1;
                    if (m_ack) begin
                        op_read  <= 1'b0;
                        op_write <= 1'b0;
                        state    <= GAP;
                        if (grant) begin
                            p1_ack <= 1'b1;
                            if (op_read) p1_rdata <= m_rdata;
                        end else begin
                            p0_ack <= 1'b1;
                            if (op_read) p0_rdata <= m_rdata;
                        end
                    end else if (count == LAST_COUNT) begin
                        op_read  <= 1'b0;
                        op_write <= 1'b0;
                        state    <= GAP;
                        if (grant) begin
                            p1_ack   <= 1'b1;
                            p1_err   <= 1'b1;
                            p1_rdata <= ERR_RDATA;
                        end else begin
                            p0_ack   <= 1'b1;
                            p0_err   <= 1'b1;
                            p0_rdata <= ERR_RDATA;
                        end
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected responses,
// a monitor checks each requester ack against them; a second instance covers fixed priority.
module tb_mem_port_arbiter;

    localparam int CTRL_LAT = 3;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc_at;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        m_read, m_write, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        grant, busy;

    logic        f0_read, f1_read, f_zero;
    logic [31:0] f0_addr, f1_addr, f_wdata;
    logic        f0_ack, f1_ack, f0_err, f1_err;
    logic [31:0] f0_rdata, f1_rdata;
    logic        f_m_read, f_m_write, f_m_ack;
    logic [31:0] f_m_addr, f_m_wdata;
    logic        f_grant, f_busy;

    logic        ctrl_ack, inject_ack, ctrl_hang, ctrl_last_write;
    int          ctrl_cnt;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb_q0[$];
    exp_t        sb_q1[$];
    int          order_q[$];
    int          fp_order_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(64), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_read(f0_read), .p0_write(f_zero), .p0_addr(f0_addr), .p0_wdata(f_wdata),
        .p0_ack(f0_ack), .p0_rdata(f0_rdata), .p0_err(f0_err),
        .p1_read(f1_read), .p1_write(f_zero), .p1_addr(f1_addr), .p1_wdata(f_wdata),
        .p1_ack(f1_ack), .p1_rdata(f1_rdata), .p1_err(f1_err),
        .m_read(f_m_read), .m_write(f_m_write), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_ack(f_m_ack), .m_rdata(f_m_addr), .grant(f_grant), .busy(f_busy)
    );

    // Controller model: acks after CTRL_LAT cycles of a held request, unless hung.
    assign m_ack   = ctrl_ack | inject_ack;
    assign m_rdata = (m_addr == 32'h10) ? 32'hDEADBEEF : (m_addr ^ 32'hCAFE0000);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_ack        <= 1'b0;
            ctrl_cnt        <= 0;
            ctrl_last_write <= 1'b0;
        end else begin
            ctrl_ack <= 1'b0;
            if (m_read || m_write) begin
                ctrl_last_write <= m_write;
                if (!ctrl_hang && ctrl_cnt == CTRL_LAT - 1) begin
                    ctrl_ack <= 1'b1;
                    ctrl_cnt <= 0;
                end else begin
                    ctrl_cnt <= ctrl_cnt + 1;
                end
            end else begin
                ctrl_cnt <= 0;
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) f_m_ack <= 1'b0;
        else        f_m_ack <= (f_m_read | f_m_write) & ~f_m_ack;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_resp(input int port, input logic [31:0] rdata, input logic err,
                               input int cyc_at, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wr);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err; e.cyc_at = cyc_at;
        e.addr = addr; e.wdata = wdata; e.wr = wr;
        if (port == 0) sb_q0.push_back(e);
        else           sb_q1.push_back(e);
        order_q.push_back(port);
    endtask

    task automatic check_output(input int port, input logic [31:0] rdata, input logic err);
        exp_t e;
        int   owner;
        if ((port == 0 && sb_q0.size() == 0) || (port == 1 && sb_q1.size() == 0)
            || order_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_ack_p%0d: got ack, expected none (cycle %0d)", port, cyc);
            return;
        end
        e     = (port == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
        owner = order_q.pop_front();
        check($sformatf("owner_order_p%0d", port), 32'(port), 32'(owner));
        check($sformatf("rdata_p%0d", port), rdata, e.rdata);
        check($sformatf("err_p%0d", port), 32'(err), 32'(e.err));
        if (e.cyc_at >= 0) check($sformatf("latency_p%0d", port), 32'(cyc), 32'(e.cyc_at));
        check($sformatf("m_addr_p%0d", port), m_addr, e.addr);
        check($sformatf("m_wdata_p%0d", port), m_wdata, e.wdata);
        check($sformatf("op_write_p%0d", port), 32'(ctrl_last_write), 32'(e.wr));
        check($sformatf("grant_p%0d", port), 32'(grant), 32'(port));
        check($sformatf("idle_in_ack_p%0d", port), 32'({m_read, m_write, busy}), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (p0_ack) check_output(0, p0_rdata, p0_err);
            if (p1_ack) check_output(1, p1_rdata, p1_err);
            if (f0_ack || f1_ack) begin
                if (fp_order_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL fp_unexpected_ack: got ack, expected none (cycle %0d)", cyc);
                end else begin
                    int id;
                    id = fp_order_q.pop_front();
                    check("fp_owner", 32'(f1_ack), 32'(id));
                    check("fp_rdata", f1_ack ? f1_rdata : f0_rdata, (id == 1) ? 32'h200 : 32'h100);
                end
            end
        end
    end

    task automatic wait_ack(input int port, input int limit);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("ack_arrived_p%0d", port), 32'(ok), 32'd1);
    endtask

    task automatic apply_stimulus();
        int c, n0, n1;

        // Reset values
        reset = 1'b0;
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
        p0_addr = 0; p0_wdata = 0; p1_addr = 0; p1_wdata = 0;
        f0_read = 0; f1_read = 0; f_zero = 0; f0_addr = 32'h100; f1_addr = 32'h200; f_wdata = 0;
        inject_ack = 0; ctrl_hang = 0;
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({p0_ack, p1_ack, p0_err, p1_err, m_read, m_write, grant, busy}), 32'd0);
        check("reset_m_addr", m_addr, 32'd0);
        check("reset_m_wdata", m_wdata, 32'd0);
        check("reset_rdata", p0_rdata | p1_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single p0 read, five-cycle request-to-ack latency
        c = cyc;
        p0_addr = 32'h10; p0_read = 1;
        expect_resp(0, 32'hDEADBEEF, 0, c + 5, 32'h10, 32'h0, 0);
        wait_ack(0, 20);
        p0_read = 0;

        // Both ports requesting continuously: grants alternate, p1 first (p0 won last)
        @(negedge clk);
        p0_addr = 32'h20; p0_read = 1;
        p1_addr = mem_bus_pkg::IO_BASE + 32'h8; p1_wdata = 32'h1FF; p1_write = 1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) expect_resp(1, 32'h0, 0, -1, 32'h00100008, 32'h1FF, 1);
            else            expect_resp(0, 32'hCAFE0020, 0, -1, 32'h20, 32'h0, 0);
        end
        n0 = 0; n1 = 0;
        for (int k = 0; k < 200 && (n0 < 4 || n1 < 4); k++) begin
            @(negedge clk);
            if (p0_ack) begin n0++; if (n0 == 4) p0_read = 0; end
            if (p1_ack) begin n1++; if (n1 == 4) p1_write = 0; end
        end
        check("rr_rounds_done", 32'(n0 + n1), 32'd8);
        p1_wdata = 0;

        // Read and write together act as a write; rdata keeps its previous value
        @(negedge clk);
        c = cyc;
        p0_addr = 32'h60; p0_wdata = 32'h1234; p0_read = 1; p0_write = 1;
        expect_resp(0, 32'hCAFE0020, 0, c + 5, 32'h60, 32'h1234, 1);
        wait_ack(0, 20);
        p0_read = 0; p0_write = 0; p0_wdata = 0;

        // Fixed priority instance: p1 wins every tie, p0 served once p1 goes quiet
        @(negedge clk);
        f0_read = 1; f1_read = 1;
        fp_order_q.push_back(1); fp_order_q.push_back(1);
        fp_order_q.push_back(1); fp_order_q.push_back(0);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 200 && n0 < 1; k++) begin
            @(negedge clk);
            if (f1_ack) begin n1++; if (n1 == 3) f1_read = 0; end
            if (f0_ack) begin n0++; f0_read = 0; end
        end
        check("fp_rounds_done", 32'(n0 + n1), 32'd4);

        // Read held through its ack cycle only: no re-issue
        @(negedge clk);
        c = cyc;
        p1_addr = 32'h40; p1_read = 1;
        expect_resp(1, 32'hCAFE0040, 0, c + 5, 32'h40, 32'h0, 0);
        wait_ack(1, 20);
        @(posedge clk);
        #1 p1_read = 0;
        repeat (4) begin
            @(negedge clk);
            check("no_reissue", 32'({m_read, m_write, busy}), 32'd0);
        end

        // Read held past the ack cycle: second transaction follows
        c = cyc;
        p1_addr = 32'h44; p1_read = 1;
        expect_resp(1, 32'hCAFE0044, 0, c + 5, 32'h44, 32'h0, 0);
        expect_resp(1, 32'hCAFE0044, 0, c + 11, 32'h44, 32'h0, 0);
        n1 = 0;
        for (int k = 0; k < 40 && n1 < 2; k++) begin
            @(negedge clk);
            if (p1_ack) begin n1++; if (n1 == 2) p1_read = 0; end
        end
        check("reissue_count", 32'(n1), 32'd2);

        // Hung controller: timeout 8 cycles after entering BUSY, then stray acks ignored
        @(negedge clk);
        c = cyc;
        ctrl_hang = 1;
        p0_addr = 32'h30; p0_read = 1;
        expect_resp(0, 32'hFFFFFFFF, 1, c + 9, 32'h30, 32'h0, 0);
        wait_ack(0, 30);
        p0_read = 0;
        inject_ack = 1;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_ignored", 32'({p0_ack, p1_ack}), 32'd0);
        end
        inject_ack = 0;
        ctrl_hang = 0;

        // Reset in the middle of a p1 transaction
        @(negedge clk);
        p1_addr = 32'h50; p1_read = 1;
        n1 = 0;
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        check("busy_before_reset", 32'({busy, grant}), 32'b11);
        #2 reset = 0;
        #1;
        check("async_reset_flags", 32'({m_read, m_write, busy, grant, p0_ack, p1_ack}), 32'd0);
        check("async_reset_rdata", p0_rdata | p1_rdata, 32'd0);
        p1_read = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        c = cyc;
        p0_addr = 32'h10; p0_read = 1;
        expect_resp(0, 32'hDEADBEEF, 0, c + 5, 32'h10, 32'h0, 0);
        wait_ack(0, 20);
        p0_read = 0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q0.size() + sb_q1.size() + fp_order_q.size()), 32'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
